// File: rtl/token_dispense_sequencer.sv
// token_dispense_sequencer
// Command sequencer in front of the colour-sorter servo block. It takes one
// request (colour + token count) at a time and turns it into spaced,
// single-cycle posRed/posGreen/posBlue/go pulses. The spacing gives the
// servo time to finish each move before it sees the next command.
// The chute colour that is currently selected is remembered, so a request
// for the same colour skips the repositioning step.

module token_dispense_sequencer #(
    parameter int unsigned POS_WAIT_TICKS  = 52000000,
    parameter int unsigned DISP_WAIT_TICKS = 102000000,
    parameter int unsigned CNT_W           = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_colour,
    input  logic [3:0] req_count,
    output logic       req_ready,
    input  logic       abort,
    output logic       posRed,
    output logic       posGreen,
    output logic       posBlue,
    output logic       go,
    output logic       busy,
    output logic       done,
    output logic [3:0] tokens_left
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        POS_WAIT  = 2'd1,
        DISP_WAIT = 2'd2
    } state_t;

    // Counter reload values. A wait of N ticks runs the counter from N-1
    // down to 0, and the next pulse is registered on the edge where it is 0.
    localparam logic [CNT_W-1:0] POS_LOAD  = CNT_W'(POS_WAIT_TICKS - 1);
    localparam logic [CNT_W-1:0] DISP_LOAD = CNT_W'(DISP_WAIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Colour encoding on the request bus and in cur_colour.
    localparam logic [1:0] COLOUR_NONE = 2'd0;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cur_colour_q, cur_colour_d;
    logic [3:0]       tokens_left_q, tokens_left_d;
    logic [2:0]       pos_q, pos_d;          // bit 0 red, bit 1 green, bit 2 blue
    logic             go_q, go_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic       accept;
    logic       need_reposition;
    logic       wait_expired;
    logic [2:0] colour_hit;

    // One-hot decode of the requested colour onto the three pos lines.
    // colour 1 -> red, 2 -> green, 3 -> blue; colour 0 hits nothing.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_colour_dec
            assign colour_hit[gi] = (req_colour == 2'(gi + 1));
        end
    endgenerate

    // The done cycle still belongs to the finishing request (busy is high
    // there), so a new request is only taken once busy has dropped. This
    // also keeps req_ready low for the whole visible lifetime of a request.
    assign req_ready = (state_q == IDLE) && !busy_q && !rst;

    assign accept = req_valid && req_ready;

    // A move is needed only for an explicit colour that differs from the
    // one the chute is known to be at. After reset cur_colour is 0, which
    // never matches an explicit colour, so the first coloured request moves.
    assign need_reposition = (req_colour != COLOUR_NONE) &&
                             (req_colour != cur_colour_q);

    assign wait_expired = (cnt_q == '0);

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // Compute the next value of every register; all pulse outputs default
    // to 0 so each pulse is exactly one cycle wide.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_colour_d  = cur_colour_q;
        tokens_left_d = tokens_left_q;
        pos_d         = 3'b000;
        go_d          = 1'b0;
        done_d        = 1'b0;
        // busy follows the state one cycle late, which makes it cover the
        // done cycle and drop in the cycle after.
        busy_d        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // abort has no effect here.
                if (accept) begin
                    busy_d = 1'b1;
                    if (need_reposition) begin
                        pos_d         = colour_hit;
                        cur_colour_d  = req_colour;
                        tokens_left_d = req_count;
                        cnt_d         = POS_LOAD;
                        state_d       = POS_WAIT;
                    end else if (req_count != 4'd0) begin
                        // Chute already in place: dispense straight away.
                        go_d          = 1'b1;
                        tokens_left_d = req_count - 4'd1;
                        cnt_d         = DISP_LOAD;
                        state_d       = DISP_WAIT;
                    end else begin
                        // Nothing to move and nothing to dispense.
                        done_d        = 1'b1;
                        tokens_left_d = 4'd0;
                        state_d       = IDLE;
                    end
                end
            end

            POS_WAIT,
            DISP_WAIT: begin
                // abort only cancels pending dispenses; the running wait is
                // allowed to finish because the servo is already moving.
                if (abort) begin
                    tokens_left_d = 4'd0;
                end

                if (!wait_expired) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!abort && (tokens_left_q != 4'd0)) begin
                    // Either the move has settled or the previous token has
                    // dropped: fire the next dispense.
                    go_d          = 1'b1;
                    tokens_left_d = tokens_left_q - 4'd1;
                    cnt_d         = DISP_LOAD;
                    state_d       = DISP_WAIT;
                end else begin
                    done_d        = 1'b1;
                    tokens_left_d = 4'd0;
                    state_d       = IDLE;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean idle.
                state_d       = IDLE;
                cnt_d         = '0;
                tokens_left_d = 4'd0;
                busy_d        = 1'b0;
            end
        endcase
    end

    // Register every state and output bit; reset returns all of them to
    // their idle values and forgets the chute position.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cur_colour_q  <= COLOUR_NONE;
            tokens_left_q <= 4'd0;
            pos_q         <= 3'b000;
            go_q          <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_colour_q  <= cur_colour_d;
            tokens_left_q <= tokens_left_d;
            pos_q         <= pos_d;
            go_q          <= go_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign posRed      = pos_q[0];
    assign posGreen    = pos_q[1];
    assign posBlue     = pos_q[2];
    assign go          = go_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign tokens_left = tokens_left_q;

endmodule
